// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
// Imported by mem_lsu and lsu_lane.
package lsu_pkg;

  typedef enum logic [3:0] {
    NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE, BUSY, RESP
  } lsu_state_e;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_DBE  = 32'h0000_0007;

  function automatic logic op_is_byte(lsu_op_e op);
    return op inside {LB, LBU, SB};
  endfunction

  function automatic logic op_is_half(lsu_op_e op);
    return op inside {LH, LHU, SH};
  endfunction

  function automatic logic op_is_word(lsu_op_e op);
    return op inside {LW, SW, LL, SC};
  endfunction

  function automatic logic op_is_store(lsu_op_e op);
    return op inside {SB, SH, SW, SC};
  endfunction

  function automatic logic op_misaligned(
    lsu_op_e    op,
    logic [1:0] a
  );
    return (op_is_half(op) & a[0])
         | (op_is_word(op) & (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store sel/wdata generation and load extraction.
// Purely combinational; lane order set by BIG_ENDIAN.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  lsu_op_e     st_op,
  input  logic [1:0]  st_addr,
  input  logic [31:0] sdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  input  lsu_op_e     ld_op,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [1:0]  st_lane;
  logic [1:0]  ld_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // physical lane index: big-endian puts address 0 in the top byte
  assign st_lane = BIG_ENDIAN ? ~st_addr : st_addr;
  assign ld_lane = BIG_ENDIAN ? ~ld_addr : ld_addr;

  assign ld_byte = rdata[{ld_lane, 3'b000} +: 8];
  assign ld_half = rdata[{ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    sel   = 4'b1111;
    wdata = sdata;
    unique case (1'b1)
      op_is_byte(st_op): begin
        sel   = 4'b0001 << st_lane;
        wdata = {4{sdata[7:0]}};
      end
      op_is_half(st_op): begin
        sel   = st_lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
      end
      default: begin
        sel   = 4'b1111;
        wdata = sdata;
      end
    endcase
  end

  always_comb begin
    ldata = rdata;
    unique case (ld_op)
      LB:      ldata = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ldata = {24'h0, ld_byte};
      LH:      ldata = {{16{ld_half[15]}}, ld_half};
      LHU:     ldata = {16'h0, ld_half};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle MEM-stage load/store unit with req/ack bus,
// misalignment and timeout faults, and the LL/SC llbit.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  lsu_op_e           i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_sdata,
  input  logic              i_flush,
  input  logic              i_llbit_clr,
  output logic              o_stall,
  output logic              o_res_vld,
  output logic [31:0]       o_res,
  output logic [31:0]       o_except_type,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_sel,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata,
  output logic              o_llbit
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e state_q;
  lsu_state_e state_d;

  lsu_op_e           op_q;
  logic [1:0]        alo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       res_q;
  logic [31:0]       exc_q;
  logic              acked_q;
  logic              flush_q;
  logic              llbit_q;

  logic        start;
  logic        mis;
  logic        sc_skip;
  logic        busy;
  logic        flushed;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [31:0] ldata_c;

  assign start = (state_q == IDLE) & i_vld
               & (i_op != NONE) & ~i_flush;
  assign mis     = op_misaligned(i_op, i_addr[1:0]);
  assign sc_skip = (i_op == SC) & ~llbit_q;
  assign busy    = (state_q == BUSY);
  assign flushed = flush_q | i_flush;

  lsu_lane #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .st_op  (i_op),
    .st_addr(i_addr[1:0]),
    .sdata  (i_sdata),
    .sel    (sel_c),
    .wdata  (wdata_c),
    .ld_op  (op_q),
    .ld_addr(alo_q),
    .rdata  (i_bus_rdata),
    .ldata  (ldata_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_stall = start;
        if (start)
          state_d = (mis | sc_skip) ? RESP : BUSY;
      end
      BUSY: begin
        o_stall = 1'b1;
        if (i_bus_ack || (cnt_q == CNT_LAST))
          state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q    <= NONE;
      alo_q   <= 2'b00;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      res_q   <= 32'h0;
      exc_q   <= EXC_NONE;
      acked_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= i_op;
            alo_q   <= i_addr[1:0];
            addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
            sel_q   <= sel_c;
            we_q    <= op_is_store(i_op);
            wdata_q <= wdata_c;
            cnt_q   <= '0;
            res_q   <= 32'h0;
            acked_q <= 1'b0;
            flush_q <= 1'b0;
            if (!mis)
              exc_q <= EXC_NONE;
            else if (op_is_store(i_op))
              exc_q <= EXC_ADES;
            else
              exc_q <= EXC_ADEL;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (i_flush) flush_q <= 1'b1;
          if (i_bus_ack) begin
            acked_q <= 1'b1;
            if (op_q == SC)
              res_q <= 32'd1;
            else if (we_q)
              res_q <= 32'h0;
            else
              res_q <= ldata_c;
          end else if (cnt_q == CNT_LAST) begin
            exc_q <= EXC_DBE;
          end
        end
        RESP: cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  // llbit only moves on a completed, unflushed LL/SC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      llbit_q <= 1'b0;
    else if (i_llbit_clr)
      llbit_q <= 1'b0;
    else if ((state_q == RESP) && acked_q && !flushed) begin
      if (op_q == LL)      llbit_q <= 1'b1;
      else if (op_q == SC) llbit_q <= 1'b0;
    end
  end

  assign o_res_vld     = (state_q == RESP) & ~flushed;
  assign o_res         = o_res_vld ? res_q : 32'h0;
  assign o_except_type = o_res_vld ? exc_q : EXC_NONE;
  assign o_bus_req     = busy;
  assign o_bus_we      = busy & we_q;
  assign o_bus_addr    = busy ? addr_q : '0;
  assign o_bus_sel     = busy ? sel_q : 4'b0000;
  assign o_bus_wdata   = busy ? wdata_q : 32'h0;
  assign o_llbit       = llbit_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised bench for mem_lsu against a transaction-level model,
// plus directed cases with literal expectations.
module tb_mem_lsu;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  lsu_op_e     op;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        flush;
  logic        llclr;
  logic        ack;
  logic [31:0] rdata;

  logic        stall;
  logic        res_vld;
  logic [31:0] res;
  logic [31:0] exc;
  logic        req;
  logic        we;
  logic [31:0] baddr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        llbit;

  always #5 clk = ~clk;

  mem_lsu #(
    .ADDR_W    (32),
    .BIG_ENDIAN(1'b1),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_vld        (vld),
    .i_op         (op),
    .i_addr       (addr),
    .i_sdata      (sdata),
    .i_flush      (flush),
    .i_llbit_clr  (llclr),
    .o_stall      (stall),
    .o_res_vld    (res_vld),
    .o_res        (res),
    .o_except_type(exc),
    .o_bus_req    (req),
    .o_bus_we     (we),
    .o_bus_addr   (baddr),
    .o_bus_sel    (sel),
    .o_bus_wdata  (wdata),
    .i_bus_ack    (ack),
    .i_bus_rdata  (rdata),
    .o_llbit      (llbit)
  );

  int errors = 0;
  int checks = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_we, e_vld, e_llbit, e_wd_chk;
  logic [31:0] e_addr, e_wdata, e_res, e_exc;
  logic [3:0]  e_sel;

  int          n_req, n_stall;
  logic        c_vld, wd_stable;
  logic [31:0] c_res, c_exc, c_wdata, c_addr;
  logic [3:0]  c_sel;

  logic m_llbit;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("bus_req", 32'(req), 32'(e_req));
      chk("res_vld", 32'(res_vld), 32'(e_vld));
      chk("llbit", 32'(llbit), 32'(e_llbit));
      if (e_req) begin
        chk("bus_we", 32'(we), 32'(e_we));
        chk("bus_addr", baddr, e_addr);
        chk("bus_sel", 32'(sel), 32'(e_sel));
        if (e_wd_chk) chk("bus_wdata", wdata, e_wdata);
      end
      if (e_vld) begin
        chk("res", res, e_res);
        chk("except", exc, e_exc);
      end
      if (stall) n_stall++;
      if (req) begin
        n_req++;
        if (n_req > 1 && wdata !== c_wdata) wd_stable = 1'b0;
        c_wdata = wdata;
        c_sel   = sel;
        c_addr  = baddr;
      end
      if (res_vld) begin
        c_vld = 1'b1;
        c_res = res;
        c_exc = exc;
      end
    end
  end

  task automatic clr_cap();
    n_req = 0;
    n_stall = 0;
    c_vld = 1'b0;
    wd_stable = 1'b1;
    c_res = 32'h0;
    c_exc = 32'h0;
    c_wdata = 32'h0;
    c_addr = 32'h0;
    c_sel = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_stall = 1'b0; e_req = 1'b0; e_vld = 1'b0;
    e_we = 1'b0; e_wd_chk = 1'b0; e_llbit = m_llbit;
  endtask

  task automatic run_txn(
    input lsu_op_e     t_op,
    input logic [31:0] t_addr,
    input logic [31:0] t_sdata,
    input int          wt,
    input logic [31:0] t_rdata,
    input int          flush_at,
    input bit          clr0,
    input bit          clr_resp,
    input bit          busy_clr
  );
    bit is_b, is_h, is_w, is_st, mis, skip, tmo, acked, flushed;
    int nb, ai;
    logic [31:0] x_res, x_exc, x_wd, shb, shh;
    logic [3:0]  x_sel;
    logic [7:0]  b8;
    logic [15:0] h16;
    ai    = int'(t_addr[1:0]);
    is_b  = t_op inside {LB, LBU, SB};
    is_h  = t_op inside {LH, LHU, SH};
    is_w  = t_op inside {LW, SW, LL, SC};
    is_st = t_op inside {SB, SH, SW, SC};
    mis   = (is_h && ai % 2 == 1) || (is_w && ai != 0);
    skip  = mis || (t_op == SC && !m_llbit);
    tmo   = !skip && wt >= TMO;
    nb    = skip ? 0 : (tmo ? TMO : wt + 1);
    acked = !skip && !tmo;
    flushed = !skip && flush_at >= 0 && flush_at < nb;
    if (is_b) begin
      x_sel = 4'b1000 >> ai;
      x_wd  = {4{t_sdata[7:0]}};
    end else if (is_h) begin
      x_sel = (ai >= 2) ? 4'b0011 : 4'b1100;
      x_wd  = {2{t_sdata[15:0]}};
    end else begin
      x_sel = 4'b1111;
      x_wd  = t_sdata;
    end
    shb = t_rdata >> (8 * (3 - ai));
    shh = t_rdata >> (16 * (1 - ai / 2));
    b8  = shb[7:0];
    h16 = shh[15:0];
    case (t_op)
      LB:      x_res = {{24{b8[7]}}, b8};
      LBU:     x_res = {24'h0, b8};
      LH:      x_res = {{16{h16[15]}}, h16};
      LHU:     x_res = {16'h0, h16};
      LW, LL:  x_res = t_rdata;
      SC:      x_res = 32'd1;
      default: x_res = 32'h0;
    endcase
    if (!acked) x_res = 32'h0;
    x_exc = mis ? (is_st ? 32'h5 : 32'h4) : (tmo ? 32'h7 : 32'h0);

    clr_cap();
    vld = 1'b1; op = t_op; addr = t_addr; sdata = t_sdata;
    flush = 1'b0; llclr = clr0;
    ack = 1'($urandom_range(0, 1)); rdata = $urandom;
    idle_exp();
    e_stall = 1'b1;
    step();
    if (clr0) m_llbit = 1'b0;

    for (int k = 0; k < nb; k++) begin
      vld = 1'($urandom_range(0, 1));
      op = lsu_op_e'(4'($urandom_range(0, 10)));
      addr = $urandom; sdata = $urandom;
      ack = (k == wt);
      rdata = (k == wt) ? t_rdata : $urandom;
      flush = (k == flush_at);
      llclr = busy_clr && (k == 0);
      idle_exp();
      e_stall = 1'b1; e_req = 1'b1; e_we = is_st;
      e_addr = {t_addr[31:2], 2'b00};
      e_sel = x_sel; e_wdata = x_wd; e_wd_chk = is_st;
      step();
      if (llclr) m_llbit = 1'b0;
    end

    vld = 1'($urandom_range(0, 1));
    op = lsu_op_e'(4'($urandom_range(0, 10)));
    flush = 1'b0; llclr = clr_resp;
    ack = 1'($urandom_range(0, 1)); rdata = $urandom;
    idle_exp();
    e_vld = !flushed; e_res = x_res; e_exc = x_exc;
    step();
    if (clr_resp) m_llbit = 1'b0;
    else if (acked && !flushed && t_op == LL) m_llbit = 1'b1;
    else if (acked && !flushed && t_op == SC) m_llbit = 1'b0;
    vld = 1'b0; flush = 1'b0; llclr = 1'b0; ack = 1'b0;
    idle_exp();
  endtask

  task automatic gap_cycle();
    int kind;
    kind = $urandom_range(0, 2);
    vld = (kind != 0);
    op = (kind == 1) ? NONE : lsu_op_e'(4'($urandom_range(1, 10)));
    flush = (kind == 2);
    llclr = 1'b0;
    ack = 1'($urandom_range(0, 1));
    rdata = $urandom;
    idle_exp();
    step();
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; op = NONE; addr = 32'h0; sdata = 32'h0;
    flush = 1'b0; llclr = 1'b0; ack = 1'b0; rdata = 32'h0;
    m_llbit = 1'b0;
    clr_cap();
    idle_exp();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_vld", 32'(res_vld), 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_exc", exc, 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_llbit", 32'(llbit), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk_en = 1'b1;

    run_txn(LB, 32'h103, 32'h0, 0, 32'h1122_3380, -1, 0, 0, 0);
    chk("lb_res", c_res, 32'hFFFF_FF80);
    chk("lb_sel", 32'(c_sel), 32'h1);
    chk("lb_stall_cycles", n_stall, 2);

    run_txn(SH, 32'h202, 32'h0000_BEEF, 3, 32'h0, -1, 0, 0, 0);
    chk("sh_addr", c_addr, 32'h200);
    chk("sh_sel", 32'(c_sel), 32'h3);
    chk("sh_wdata", c_wdata, 32'hBEEF_BEEF);
    chk("sh_req_cycles", n_req, 4);
    chk("sh_wdata_stable", 32'(wd_stable), 32'h1);

    run_txn(LW, 32'h101, 32'h0, 0, 32'h0, -1, 0, 0, 0);
    chk("lw_mis_req", n_req, 0);
    chk("lw_mis_exc", c_exc, 32'h4);
    run_txn(SW, 32'h102, 32'h0, 0, 32'h0, -1, 0, 0, 0);
    chk("sw_mis_exc", c_exc, 32'h5);

    run_txn(LL, 32'h40, 32'h0, 1, 32'hCAFE_F00D, -1, 0, 0, 0);
    chk("ll_llbit", 32'(llbit), 32'h1);
    chk("ll_res", c_res, 32'hCAFE_F00D);
    run_txn(SC, 32'h40, 32'h1234_5678, 0, 32'h0, -1, 0, 0, 0);
    chk("sc_res", c_res, 32'h1);
    chk("sc_llbit", 32'(llbit), 32'h0);
    run_txn(SC, 32'h40, 32'h1234_5678, 0, 32'h0, -1, 0, 0, 0);
    chk("sc2_req", n_req, 0);
    chk("sc2_res", c_res, 32'h0);
    chk("sc2_vld", 32'(c_vld), 32'h1);

    run_txn(LW, 32'h80, 32'h0, 10, 32'h0, -1, 0, 0, 0);
    chk("tmo_req_cycles", n_req, 4);
    chk("tmo_exc", c_exc, 32'h7);

    run_txn(LW, 32'h84, 32'h0, 3, 32'h5555_AAAA, 1, 0, 0, 0);
    chk("flush_vld", 32'(c_vld), 32'h0);
    chk("flush_req_cycles", n_req, 4);

    run_txn(LL, 32'h48, 32'h0, 0, 32'h0, -1, 0, 1, 0);
    chk("llclr_wins", 32'(llbit), 32'h0);

    for (int i = 0; i < 400; i++) begin
      lsu_op_e     r_op;
      logic [31:0] r_addr;
      int          r_fl;
      r_op = lsu_op_e'(4'($urandom_range(1, 10)));
      if ($urandom_range(0, 3) == 0) r_op = ($urandom_range(0, 1) != 0) ? LL : SC;
      r_addr = $urandom;
      if ($urandom_range(0, 2) != 0) r_addr[1:0] = 2'b00;
      r_fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(r_op, r_addr, $urandom, int'($urandom_range(0, 5)), $urandom, r_fl,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 15) == 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) gap_cycle();
    end

    run_txn(LL, 32'h60, 32'h0, 0, 32'h0, -1, 0, 0, 0);
    chk("pre_rst_llbit", 32'(llbit), 32'h1);
    chk_en = 1'b0;
    vld = 1'b1; op = LW; addr = 32'h100; ack = 1'b0;
    step();
    vld = 1'b0; op = NONE;
    step();
    #2;
    chk("busy_req", 32'(req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_busy_req", 32'(req), 32'h0);
    chk("rst_busy_stall", 32'(stall), 32'h0);
    chk("rst_busy_llbit", 32'(llbit), 32'h0);
    chk("rst_busy_sel", 32'(sel), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Multi-cycle load/store unit for the MEM stage. Replaces the single-cycle, combinational memory access with a req/ack bus handshake, so the data bus can have wait states.
- Stalls the pipeline while an access is outstanding and performs byte-lane steering and sign or zero extension.
- Detects misaligned accesses, enforces a bus timeout, and owns the LL/SC llbit.
- Sits between ex_mem and mem_wb. Its output feeds the mem_wb register and the ctrl stall logic.

Parameters:
- ADDR_W, 32, data bus address width.
- BIG_ENDIAN, 1, lane order. 1: byte at addr[1:0]=00 is rdata[31:24]. 0: it is rdata[7:0].
- TIMEOUT, 255, number of BUSY cycles without ack before a bus error; legal range 2..1023.

Ports:
- i_clk in 1: clock.
- i_rst in 1: asynchronous, active-high reset.
- i_vld in 1: MEM-stage instruction valid.
- i_op in lsu_op_e: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
- i_addr in ADDR_W: effective address.
- i_sdata in 32: store data (rt).
- i_flush in 1: pipeline flush (exception or ERET taken).
- i_llbit_clr in 1: clear llbit (ERET).
- o_stall in/out: out 1: stall request to ctrl.
- o_res_vld out 1: result valid, one-cycle pulse.
- o_res out 32: load result; for SC, 1 = success, 0 = fail.
- o_except_type out 32: 0 when no exception, else 0x04 AdEL, 0x05 AdES, 0x07 DBE.
- o_bus_req out 1: bus request.
- o_bus_we out 1: bus write enable.
- o_bus_addr out ADDR_W: word-aligned bus address.
- o_bus_sel out 4: byte enables.
- o_bus_wdata out 32: bus write data.
- i_bus_ack in 1: bus acknowledge.
- i_bus_rdata in 32: bus read data.
- o_llbit out 1: current llbit.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE; llbit = 0; timeout counter = 0.
  - Asserting i_rst mid-access drops o_bus_req immediately and discards the access.
- start = IDLE & i_vld & (i_op != NONE) & ~i_flush.
- Misalignment check, evaluated at start:
  - Halfword ops fault when addr[0] = 1.
  - Word ops (LW, SW, LL, SC) fault when addr[1:0] != 0.
  - Loads and LL report AdEL; stores and SC report AdES.
  - No bus access is made. Next cycle: state RESP, o_except_type = code, o_res = 0.
- SC with llbit = 0: no bus access. Next cycle: RESP with o_res = 0.
- States:
  - IDLE: on a legal start, register bus address, sel, we and wdata and go to BUSY.
    - o_stall = start, combinational.
  - BUSY: o_bus_req = 1; all bus outputs held stable; o_stall = 1.
    - Counter increments each cycle.
    - On i_bus_ack: capture rdata and go to RESP.
    - On counter = TIMEOUT-1 without ack: drop req, go to RESP with DBE.
  - RESP: one cycle. o_res_vld = 1 unless flushed; o_stall = 0. Then IDLE.
- Latency: a zero-wait-state ack (ack in the first BUSY cycle) gives o_res_vld 2 cycles after start.
- Byte lanes (BIG_ENDIAN = 1):
  - SB: sel = 1000 >> addr[1:0]; wdata = byte replicated ×4.
  - SH: sel = 1100 or 0011; wdata = half replicated ×2.
  - Word ops: sel = 1111.
  - Loads extract the same lane; LB and LH sign-extend, LBU and LHU zero-extend.
  - BIG_ENDIAN = 0 mirrors the lane index.
- o_bus_addr = {addr[ADDR_W-1:2], 2'b00}.
- i_flush during BUSY:
  - The transaction completes; there is no bus abort.
  - The result and the llbit update are discarded.
  - RESP produces o_res_vld = 0 and o_except_type = 0.
- Spurious i_bus_ack in IDLE or RESP is ignored.
- llbit:
  - LL completion sets it to 1.
  - Successful SC completion clears it.
  - i_llbit_clr clears it and wins over a simultaneous LL set.
  - A bus error on LL or SC leaves llbit unchanged.
- A DBE on SC reports o_res = 0.

Decomposition:
- Package lsu_pkg:
  - lsu_op_e enum.
  - lsu_state_e enum (IDLE, BUSY, RESP).
  - Exception code constants EXC_ADEL, EXC_ADES, EXC_DBE.
- Sub-module lsu_lane: combinational sel/wdata generation and load extraction, parametrised by BIG_ENDIAN. The FSM, counter and llbit stay in mem_lsu.

Test Plan:
- LB at addr 0x103, zero-wait ack, rdata 0x11223380 -> sel 0001, o_res = 0xFFFFFF80 two cycles after start; o_stall high for exactly 2 cycles.
- SH at addr 0x202, sdata 0x0000BEEF, ack after 3 wait cycles -> bus addr 0x200, sel 0011, wdata 0xBEEFBEEF held stable for 4 cycles, o_res_vld one cycle after ack.
- LW at addr 0x101 -> no o_bus_req; o_except_type = 0x04 in RESP. SW at addr 0x102 -> 0x05.
- LL at addr 0x40, then SC at 0x40 -> o_res = 1, llbit goes 1 then 0. Repeat the SC -> no bus req, o_res = 0.
- TIMEOUT = 4, no ack -> o_bus_req high 4 cycles then low; o_except_type = 0x07; o_stall drops.
- i_flush in the second BUSY cycle of an LW -> access completes on ack, o_res_vld stays 0. Separately, i_rst asserted in BUSY -> o_bus_req = 0 immediately.
